sqrt_fpu: RTL and testbench

SQRT_FPU -- requirements
Module: sqrt_fpu

---
 rtl/sqrt_fpu.sv | 150 +++++++++++++++
 tb/tb_sqrt_fpu.sv | 113 +++++++++++
 2 files changed

// File: rtl/sqrt_fpu.sv
// Single-cycle IEEE-754 binary32 square root, round-to-nearest-even, registered outputs.
// Optional macro SQRT_FPU_SUBNORMAL_EN: normalize subnormal operands instead of flushing them.
module sqrt_fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    logic        sign;
    logic [7:0]  bexp;
    logic [22:0] frac_in;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        is_sub;

    assign sign    = A[31];
    assign bexp    = A[30:23];
    assign frac_in = A[22:0];
    assign is_nan  = (bexp == 8'hFF) && (frac_in != 23'd0);
    assign is_inf  = (bexp == 8'hFF) && (frac_in == 23'd0);
    assign is_zero = (bexp == 8'h00) && (frac_in == 23'd0);
    assign is_sub  = (bexp == 8'h00) && (frac_in != 23'd0);

    // Significand 1.m in sig[23:0] and unbiased exponent before the parity fix-up.
    logic [23:0]       sig;
    logic signed [9:0] e_raw;

`ifdef SQRT_FPU_SUBNORMAL_EN
    logic [4:0] msb_pos;
    logic [4:0] shift;

    always_comb begin
        msb_pos = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (frac_in[i]) msb_pos = 5'(i);
        end
        shift = 5'd23 - msb_pos;
    end

    always_comb begin
        if (is_sub) begin
            sig   = {1'b0, frac_in} << shift;
            e_raw = -10'sd126 - $signed({5'b00000, shift});
        end else begin
            sig   = {1'b1, frac_in};
            e_raw = $signed({2'b00, bexp}) - 10'sd127;
        end
    end
`else
    assign sig   = {1'b1, frac_in};
    assign e_raw = $signed({2'b00, bexp}) - 10'sd127;
`endif

    // Odd exponents move one factor of two into the radicand so the halving is exact.
    logic              e_odd;
    logic signed [9:0] e_even;
    logic [49:0]       rad;

    assign e_odd  = e_raw[0];
    assign e_even = e_odd ? (e_raw - 10'sd1) : e_raw;
    assign rad    = e_odd ? {sig, 26'd0} : {1'b0, sig, 25'd0};

    // Unrolled restoring root: 25 result bits (24-bit significand plus guard).
    logic [24:0] q;
    logic [27:0] rem_v;
    logic [27:0] trial;

    always_comb begin
        q     = 25'd0;
        rem_v = 28'd0;
        trial = 28'd0;
        for (int i = 24; i >= 0; i--) begin
            rem_v = {rem_v[25:0], rad[2*i+1 -: 2]};
            trial = {1'b0, q, 2'b01};
            if (rem_v >= trial) begin
                rem_v = rem_v - trial;
                q     = {q[23:0], 1'b1};
            end else begin
                q     = {q[23:0], 1'b0};
            end
        end
    end

    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [24:0]       sum;
    logic [22:0]       frac_out;
    logic signed [9:0] res_e;

    assign guard    = q[0];
    assign sticky   = (rem_v != 28'd0);
    assign round_up = guard & (sticky | q[1]);
    assign sum      = {1'b0, q[24:1]} + {24'd0, round_up};
    // A carry out means the significand reached 2.0: shift right and bump the exponent.
    assign frac_out = sum[24] ? sum[23:1] : sum[22:0];
    assign res_e    = (e_even >>> 1) + 10'sd127 + (sum[24] ? 10'sd1 : 10'sd0);

    logic [31:0] result_d;
    logic        underflow_d;
    logic        exception_d;

    always_comb begin
        result_d    = 32'd0;
        underflow_d = 1'b0;
        exception_d = 1'b0;
        if (is_nan) begin
            result_d    = QNAN;
            exception_d = 1'b1;
        end else if (is_zero) begin
            result_d = {sign, 31'd0};
        end else if (sign) begin
            result_d    = QNAN;
            exception_d = 1'b1;
        end else if (is_inf) begin
            result_d = PINF;
        end else begin
            result_d = {1'b0, res_e[7:0], frac_out};
`ifndef SQRT_FPU_SUBNORMAL_EN
            if (is_sub) begin
                result_d    = 32'd0;
                underflow_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else begin
            result    <= result_d;
            overflow  <= 1'b0;
            underflow <= underflow_d;
            exception <= exception_d;
        end
    end

endmodule

// File: tb/tb_sqrt_fpu.sv
// Directed-vector bench for sqrt_fpu; expected results are hand-computed binary32 roots.
// Build with SQRT_FPU_SUBNORMAL_EN defined to check the normalizing subnormal path.
module tb_sqrt_fpu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        exception;

    int checks = 0;
    int errors = 0;

    sqrt_fpu dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, expv);
        end
    endtask

    // Drive an operand between edges, then check all outputs just after the next rising edge.
    task automatic apply(input string tag, input logic [31:0] a_in, input logic [31:0] exp_res,
                         input logic exp_exc, input logic exp_unf);
        @(negedge clk);
        A = a_in;
        @(posedge clk);
        #1;
        check({tag, ".result"},    result,            exp_res);
        check({tag, ".exception"}, {31'd0, exception}, {31'd0, exp_exc});
        check({tag, ".underflow"}, {31'd0, underflow}, {31'd0, exp_unf});
        check({tag, ".overflow"},  {31'd0, overflow},  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        A   = 32'h4080_0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result",    result,             32'd0);
        check("reset.exception", {31'd0, exception}, 32'd0);
        check("reset.underflow", {31'd0, underflow}, 32'd0);
        check("reset.overflow",  {31'd0, overflow},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply("sqrt4",    32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0);
        apply("sqrt9",    32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0);
        apply("sqrt2",    32'h4000_0000, 32'h3FB5_04F3, 1'b0, 1'b0);
        apply("sqrt0p25", 32'h3E80_0000, 32'h3F00_0000, 1'b0, 1'b0);
        apply("sqrt1",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
        apply("sqrt16",   32'h4180_0000, 32'h4080_0000, 1'b0, 1'b0);
        apply("sqrt0p5",  32'h3F00_0000, 32'h3F35_04F3, 1'b0, 1'b0);
        apply("maxnorm",  32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0, 1'b0);
        apply("minnorm",  32'h0080_0000, 32'h2000_0000, 1'b0, 1'b0);
        apply("pzero",    32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        apply("nzero",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        apply("pinf",     32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0);
        apply("neg1",     32'hBF80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
        apply("nan",      32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 1'b0);
        apply("ninf",     32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0);
        apply("negsub",   32'h8000_0001, 32'h7FC0_0000, 1'b1, 1'b0);
`ifdef SQRT_FPU_SUBNORMAL_EN
        apply("sub1",     32'h0000_0001, 32'h1A35_04F3, 1'b0, 1'b0);
        apply("subtop",   32'h0040_0000, 32'h1FB5_04F3, 1'b0, 1'b0);
`else
        apply("sub1",     32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
        apply("subtop",   32'h0040_0000, 32'h0000_0000, 1'b0, 1'b1);
`endif

        // Unchanged operand keeps the outputs steady across edges.
        apply("hold", 32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("hold.result", result, 32'h4040_0000);

        // Asynchronous reset clears outputs between edges; first edge after release loads new A.
        apply("prerst", 32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.result", result, 32'd0);
        A = 32'h4110_0000;
        #1;
        rst = 1'b0;
        #1;
        check("rst_released.result", result, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst.result",    result,             32'h4040_0000);
        check("post_rst.exception", {31'd0, exception}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
